dnn_mlp_seq: RTL

Parametrised two-layer MLP inference engine (N_IN inputs -> N_HID hidden neurons -> N_OUT outputs) with a configurable hidden-layer activation.
- LANES signed multiply-accumulate lanes are time-multiplexed across both layers; each lane takes one product per cycle.
- Inputs and weights are captured on a valid/ready accept; results leave through a valid/ready port with backpressure.
- Successor to the fixed 4-4-2 engine: sizes, lane count and activation are parametrised, and it adds handshakes, reset, and weight capture.

---
 rtl/dnn_mlp_seq_if.sv | 29 ++
 rtl/dnn_mlp_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_mlp_seq_if.sv
// Handshake/data bundle for the dnn_mlp_seq engine.
// master drives the request and consumes results; slave is the engine.
interface dnn_mlp_seq_if #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int XW    = 7,
  parameter int WW    = 5,
  parameter int OW    = XW + WW + $clog2(N_IN) + WW + $clog2(N_HID)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_IN*XW-1:0]         x_flat;
  logic [N_IN*N_HID*WW-1:0]   w1_flat;
  logic [N_HID*N_OUT*WW-1:0]  w2_flat;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_OUT*OW-1:0]        out_flat;

  modport master (
    output in_valid, x_flat, w1_flat, w2_flat, out_ready,
    input  in_ready, out_valid, out_flat
  );

  modport slave (
    input  in_valid, x_flat, w1_flat, w2_flat, out_ready,
    output in_ready, out_valid, out_flat
  );
endinterface

// File: rtl/dnn_mlp_seq.sv
// Two-layer MLP inference engine (N_IN -> N_HID -> N_OUT) built on LANES
// time-multiplexed signed MAC lanes shared by both layers.
// Optional macro DNN_HID_TAP_EN exposes the post-activation hidden layer
// (hid_flat) and a one-cycle hid_valid strobe on the first L2 cycle.

// One MAC lane: accumulates a*b; sum is the running total including the
// current product, so the writeback cycle needs no extra pipeline stage.
module dnn_mlp_lane #(
  parameter int AW  = 14,
  parameter int BW  = 5,
  parameter int ACW = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic signed [AW-1:0]  a,
  input  logic signed [BW-1:0]  b,
  output logic [ACW-1:0]        sum
);
  logic signed [AW+BW-1:0] prod;
  logic signed [ACW-1:0]   acc;

  assign prod = a * b;
  assign sum  = acc + ACW'(prod);

  // Accumulate while busy; the last term of a group restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (en)  acc <= clr ? '0 : sum;
  end
endmodule

module dnn_mlp_seq #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int XW    = 7,
  parameter int WW    = 5,
  parameter int LANES = 2,
  parameter int ACT   = 1,
  localparam int HW   = XW + WW + $clog2(N_IN),
  localparam int OW   = HW + WW + $clog2(N_HID)
) (
  input  logic             clk,
  input  logic             rst_n,
  dnn_mlp_seq_if.slave     bus
`ifdef DNN_HID_TAP_EN
  ,
  output logic [N_HID*HW-1:0] hid_flat,
  output logic                hid_valid
`endif
);
  localparam int G1   = N_HID / LANES;
  localparam int G2   = N_OUT / LANES;
  localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int GMAX = (G1 > G2) ? G1 : G2;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int GW   = $clog2(GMAX + 1);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  state_t state, state_nxt;

  logic [N_IN-1:0][XW-1:0]        x_q;
  logic [N_IN*N_HID-1:0][WW-1:0]  w1_q;
  logic [N_HID*N_OUT-1:0][WW-1:0] w2_q;
  logic [N_HID-1:0][HW-1:0]       hid_q, hid_nxt;
  logic [N_OUT-1:0][OW-1:0]       out_q;
  logic [KW-1:0]                  k_cnt;
  logic [GW-1:0]                  g_cnt;
  logic                           accept, busy, last_term, last_grp;
  logic                           l1_done, l2_done;
  logic signed [HW-1:0]           op_a;
  logic [LANES-1:0][WW-1:0]       op_b;
  logic [LANES-1:0][OW-1:0]       sum;

  function automatic logic [HW-1:0] act_fn(input logic [HW-1:0] v);
    if (ACT != 0) return v & ~{HW{v[HW-1]}};
    else          return v;
  endfunction

  assign accept  = bus.in_valid && bus.in_ready;
  assign busy    = (state == L1) || (state == L2);
  assign l1_done = (state == L1) && last_term && last_grp;
  assign l2_done = (state == L2) && last_term && last_grp;

  // Loop bounds depend on which layer is running.
  always_comb begin
    if (state == L2) begin
      last_term = (k_cnt == KW'(N_HID - 1));
      last_grp  = (g_cnt == GW'(G2 - 1));
    end else begin
      last_term = (k_cnt == KW'(N_IN - 1));
      last_grp  = (g_cnt == GW'(G1 - 1));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = L1;
      L1:      if (l1_done)       state_nxt = L2;
      L2:      if (l2_done)       state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the whole operand set on accept so the source may move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      w1_q <= '0;
      w2_q <= '0;
    end else if (accept) begin
      x_q  <= bus.x_flat;
      w1_q <= bus.w1_flat;
      w2_q <= bus.w2_flat;
    end
  end

  // Term counter (inner) and group counter (outer), shared by both layers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cnt <= '0;
      g_cnt <= '0;
    end else if (accept) begin
      k_cnt <= '0;
      g_cnt <= '0;
    end else if (busy) begin
      if (last_term) begin
        k_cnt <= '0;
        g_cnt <= last_grp ? '0 : g_cnt + GW'(1);
      end else begin
        k_cnt <= k_cnt + KW'(1);
      end
    end
  end

  // Shared activation operand: x[k] in L1, hid[j] in L2.
  always_comb begin
    op_a = '0;
    if (state == L2) begin
      for (int j = 0; j < N_HID; j++)
        if (k_cnt == KW'(j)) op_a = hid_q[j];
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (k_cnt == KW'(i)) op_a = HW'(signed'(x_q[i]));
    end
  end

  // Per-lane weight select for the current (group, term).
  always_comb begin
    op_b = '0;
    for (int l = 0; l < LANES; l++) begin
      if (state == L2) begin
        for (int g = 0; g < G2; g++)
          for (int j = 0; j < N_HID; j++)
            if (g_cnt == GW'(g) && k_cnt == KW'(j))
              op_b[l] = w2_q[j*N_OUT + g*LANES + l];
      end else begin
        for (int g = 0; g < G1; g++)
          for (int i = 0; i < N_IN; i++)
            if (g_cnt == GW'(g) && k_cnt == KW'(i))
              op_b[l] = w1_q[i*N_HID + g*LANES + l];
      end
    end
  end

  dnn_mlp_lane #(.AW(HW), .BW(WW), .ACW(OW)) u_lane [LANES-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .clr   (last_term),
    .a     (op_a),
    .b     (op_b),
    .sum   (sum)
  );

  // Hidden writeback: the finishing group's slots take the activated sums.
  always_comb begin
    hid_nxt = hid_q;
    if (state == L1 && last_term)
      for (int g = 0; g < G1; g++)
        if (g_cnt == GW'(g))
          for (int l = 0; l < LANES; l++)
            hid_nxt[g*LANES + l] = act_fn(sum[l][HW-1:0]);
  end

  // Hidden register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hid_q <= '0;
    else        hid_q <= hid_nxt;
  end

  // Output register: written only when an L2 group completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (state == L2 && last_term) begin
      for (int g = 0; g < G2; g++)
        if (g_cnt == GW'(g))
          for (int l = 0; l < LANES; l++)
            out_q[g*LANES + l] <= sum[l];
    end
  end

  assign bus.out_flat = out_q;

`ifdef DNN_HID_TAP_EN
  // Snapshot of the full hidden layer at L1 completion; strobe marks first L2 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hid_flat  <= '0;
      hid_valid <= 1'b0;
    end else begin
      hid_valid <= l1_done;
      if (l1_done) hid_flat <= hid_nxt;
    end
  end
`endif
endmodule
